// File: rtl/char_pkg.sv
// char_pkg -- shared types for the character motion block.
//   motion_t : vertical motion state (GROUND / RISE / FALL)
//   seq_t    : per-tick probe sequencer state
//   MOV_*    : bit positions inside the 4-bit keypad vector
package char_pkg;

  typedef enum logic [1:0] {
    M_GROUND,
    M_RISE,
    M_FALL
  } motion_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PROBE_H,
    S_WAIT_H,
    S_PROBE_V,
    S_WAIT_V
  } seq_t;

  localparam int MOV_UP = 3;
  localparam int MOV_DN = 2;
  localparam int MOV_L  = 1;
  localparam int MOV_R  = 0;

endpackage

// File: rtl/tick_gen.sv
// tick_gen -- movement-tick prescaler.
//   sys_clk : system clock
//   rst_n   : asynchronous active-low reset
//   tick    : registered one-cycle pulse every TICK_DIV+1 cycles; the first
//             pulse follows reset release by TICK_DIV+1 cycles
module tick_gen #(
  parameter int TICK_DIV = 4999999
) (
  input  logic sys_clk,
  input  logic rst_n,
  output logic tick
);

  localparam int CW = $clog2(TICK_DIV + 1);

  // The five-cycle probe sequence must finish before the next tick.
  generate
    if (TICK_DIV < 8) begin : g_div_chk
      $error("tick_gen: TICK_DIV must be 8 or more");
    end
  endgenerate

  logic [CW-1:0] cnt;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt == CW'(TICK_DIV)) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + 1'b1;
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/char_motion.sv
// char_motion -- tick-driven character mover with block-map collision probes.
//   sys_clk, rst_n : clock, asynchronous active-low reset
//   mov            : keypad {up/jump, down (ignored), left, right}, taken at tick
//   map_req        : one-cycle probe strobe (PROBE_H / PROBE_V only)
//   map_x, map_y   : probe coordinate, stable while map_req is high
//   map_solid      : probe answer, valid the cycle after map_req
//   char_X, char_Y : registered character position
//   airborne       : high in RISE and FALL
//   tick           : movement-tick pulse
// Each tick runs IDLE->PROBE_H->WAIT_H->PROBE_V->WAIT_V->IDLE. X commits at
// the end of WAIT_H, Y and the motion state at the end of WAIT_V.
module char_motion
  import char_pkg::*;
#(
  parameter int X_W      = 10,
  parameter int Y_W      = 10,
  parameter int X_MAX    = 639,
  parameter int Y_MAX    = 479,
  parameter int X_INIT   = 143,
  parameter int Y_INIT   = 34,
  parameter int TICK_DIV = 4999999,
  parameter int JUMP_H   = 32,
  parameter int WRAP_X   = 1
) (
  input  logic           sys_clk,
  input  logic           rst_n,
  input  logic [3:0]     mov,
  output logic           map_req,
  output logic [X_W-1:0] map_x,
  output logic [Y_W-1:0] map_y,
  input  logic           map_solid,
  output logic [X_W-1:0] char_X,
  output logic [Y_W-1:0] char_Y,
  output logic           airborne,
  output logic           tick
);

  localparam int RW = $clog2(JUMP_H + 1);
  localparam logic [X_W-1:0] XMAX = X_W'(X_MAX);
  localparam logic [Y_W-1:0] YMAX = Y_W'(Y_MAX);

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .tick    (tick)
  );

  motion_t        mst;
  seq_t           seq;
  logic           jmp_l;   // jump bit captured at tick
  logic           h_en;    // an H probe was issued this tick
  logic [X_W-1:0] h_tgt;   // H target captured at tick
  logic           v_en;    // a V probe was issued this tick
  logic [RW-1:0]  rcnt;

  // Down has no effect on motion.
  logic mov_dn_unused;
  assign mov_dn_unused = mov[MOV_DN];

  assign airborne = (mst != M_GROUND);

  // Horizontal target from the keypad at tick; left beats right. A blocked
  // edge (no wrap) yields no probe at all.
  logic           h_go;
  logic [X_W-1:0] h_nx;
  always_comb begin
    h_go = 1'b0;
    h_nx = char_X;
    if (mov[MOV_L]) begin
      if (char_X == '0) begin
        if (WRAP_X != 0) begin
          h_go = 1'b1;
          h_nx = XMAX;
        end
      end else begin
        h_go = 1'b1;
        h_nx = char_X - 1'b1;
      end
    end else if (mov[MOV_R]) begin
      if (char_X == XMAX) begin
        if (WRAP_X != 0) begin
          h_go = 1'b1;
          h_nx = '0;
        end
      end else begin
        h_go = 1'b1;
        h_nx = char_X + 1'b1;
      end
    end
  end

  // X after this tick's H step (meaningful in WAIT_H); V probe uses it.
  logic [X_W-1:0] x_upd;
  assign x_upd = (h_en && !map_solid) ? h_tgt : char_X;

  // Vertical probe: above while rising, below otherwise. Screen edges act
  // as solid without touching the map.
  logic           v_up, v_go;
  logic [Y_W-1:0] v_y;
  assign v_up = (mst == M_RISE);
  assign v_go = v_up ? (char_Y != '0) : (char_Y != YMAX);
  assign v_y  = v_up ? (char_Y - 1'b1) : (char_Y + 1'b1);

  logic solid_v;
  assign solid_v = v_en ? map_solid : 1'b1;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      char_X  <= X_W'(X_INIT);
      char_Y  <= Y_W'(Y_INIT);
      mst     <= M_FALL;
      seq     <= S_IDLE;
      jmp_l   <= 1'b0;
      h_en    <= 1'b0;
      h_tgt   <= '0;
      v_en    <= 1'b0;
      rcnt    <= '0;
      map_req <= 1'b0;
      map_x   <= '0;
      map_y   <= '0;
    end else begin
      map_req <= 1'b0;
      case (seq)
        S_IDLE: begin
          if (tick) begin
            jmp_l   <= mov[MOV_UP];
            h_en    <= h_go;
            h_tgt   <= h_nx;
            map_req <= h_go;
            map_x   <= h_nx;
            map_y   <= char_Y;
            seq     <= S_PROBE_H;
          end
        end
        S_PROBE_H: seq <= S_WAIT_H;
        S_WAIT_H: begin
          char_X  <= x_upd;
          v_en    <= v_go;
          map_req <= v_go;
          map_x   <= x_upd;
          map_y   <= v_y;
          seq     <= S_PROBE_V;
        end
        S_PROBE_V: seq <= S_WAIT_V;
        S_WAIT_V: begin
          seq <= S_IDLE;
          case (mst)
            // Free space below wins over a jump request.
            M_GROUND: begin
              if (!solid_v) begin
                char_Y <= char_Y + 1'b1;
                mst    <= M_FALL;
              end else if (jmp_l) begin
                rcnt <= RW'(JUMP_H);
                mst  <= M_RISE;
              end
            end
            M_RISE: begin
              if (!solid_v) begin
                char_Y <= char_Y - 1'b1;
                rcnt   <= rcnt - 1'b1;
                if (rcnt <= RW'(1)) mst <= M_FALL;
              end else begin
                mst <= M_FALL;
              end
            end
            M_FALL: begin
              if (!solid_v) char_Y <= char_Y + 1'b1;
              else          mst    <= M_GROUND;
            end
            default: mst <= M_FALL;
          endcase
        end
        default: seq <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_char_motion.sv
module tb_char_motion;

  logic sys_clk = 1'b0;
  logic rst_n   = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // u_m: main scenario, floor row 200, wall column 99, optional ceiling 190
  // u_w: wrapping X, spawn at X_MAX, empty map
  // u_nw: blocking X, spawn at X_MAX, empty map
  logic [3:0] mov_m = '0, mov_w = '0, mov_nw = '0;
  logic mreq_m, mreq_w, mreq_nw;
  logic [9:0] mx_m, mx_w, mx_nw, my_m, my_w, my_nw;
  logic ms_m = 1'b0, ms_w = 1'b0, ms_nw = 1'b0;
  logic [9:0] cx_m, cx_w, cx_nw, cy_m, cy_w, cy_nw;
  logic air_m, air_w, air_nw, tk_m, tk_w, tk_nw;
  logic ceil_on = 1'b0;

  char_motion #(.X_INIT(100), .Y_INIT(34), .TICK_DIV(8), .JUMP_H(32), .WRAP_X(1)) u_m (
    .sys_clk(sys_clk), .rst_n(rst_n), .mov(mov_m), .map_req(mreq_m), .map_x(mx_m),
    .map_y(my_m), .map_solid(ms_m), .char_X(cx_m), .char_Y(cy_m), .airborne(air_m), .tick(tk_m));

  char_motion #(.X_INIT(639), .Y_INIT(34), .TICK_DIV(8), .JUMP_H(32), .WRAP_X(1)) u_w (
    .sys_clk(sys_clk), .rst_n(rst_n), .mov(mov_w), .map_req(mreq_w), .map_x(mx_w),
    .map_y(my_w), .map_solid(ms_w), .char_X(cx_w), .char_Y(cy_w), .airborne(air_w), .tick(tk_w));

  char_motion #(.X_INIT(639), .Y_INIT(34), .TICK_DIV(8), .JUMP_H(32), .WRAP_X(0)) u_nw (
    .sys_clk(sys_clk), .rst_n(rst_n), .mov(mov_nw), .map_req(mreq_nw), .map_x(mx_nw),
    .map_y(my_nw), .map_solid(ms_nw), .char_X(cx_nw), .char_Y(cy_nw), .airborne(air_nw), .tick(tk_nw));

  // Map responders: answer one cycle after each request.
  always @(posedge sys_clk) begin
    ms_m  <= mreq_m && ((my_m == 10'd200) || (mx_m == 10'd99) || (ceil_on && my_m == 10'd190));
    ms_w  <= mreq_w && ((my_w > 10'd600) || (mx_w > 10'd700));
    ms_nw <= mreq_nw && ((my_nw > 10'd600) || (mx_nw > 10'd700));
  end

  int total = 0;
  int bad   = 0;
  int wcnt  = 0;
  logic hreq_m, hreq_w, hreq_nw;
  logic [9:0] hx_m, hx_w;

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic wait_tick();
    int k;
    k = 0;
    @(negedge sys_clk);
    while (!tk_m && k < 20) begin
      @(negedge sys_clk);
      k++;
    end
    if (!tk_m) begin
      total++;
      bad++;
      $display("FAIL tick_timeout: got no tick expected tick within 20 cycles");
    end
  endtask

  // One full tick: capture the H probe, count u_w probes, end after WAIT_V commit.
  task automatic do_tick();
    wait_tick();
    @(negedge sys_clk);
    hreq_m = mreq_m; hx_m = mx_m; hreq_w = mreq_w; hx_w = mx_w; hreq_nw = mreq_nw;
    wcnt += int'(mreq_w);
    @(negedge sys_clk);
    @(negedge sys_clk);
    wcnt += int'(mreq_w);
    @(negedge sys_clk);
    @(negedge sys_clk);
  endtask

  typedef struct {
    logic [3:0] mov;
    bit         ceil;
    int         n;
    int         ex;
    int         ey;
    bit         eair;
    bit         chk_h;
    bit         ehreq;
    int         ehx;
  } vec_t;

  vec_t tbl[16];

  initial begin
    int k;
    tbl[0]  = '{4'b0000, 1'b0, 164, 100, 199, 1'b1, 1'b0, 1'b0, 0};
    tbl[1]  = '{4'b0000, 1'b0, 1,   100, 199, 1'b0, 1'b0, 1'b0, 0};
    tbl[2]  = '{4'b0011, 1'b0, 1,   100, 199, 1'b0, 1'b1, 1'b1, 99};
    tbl[3]  = '{4'b0001, 1'b0, 1,   101, 199, 1'b0, 1'b1, 1'b1, 101};
    tbl[4]  = '{4'b0010, 1'b0, 1,   100, 199, 1'b0, 1'b1, 1'b1, 100};
    tbl[5]  = '{4'b1000, 1'b0, 1,   100, 199, 1'b1, 1'b0, 1'b0, 0};
    tbl[6]  = '{4'b0000, 1'b0, 32,  100, 167, 1'b1, 1'b1, 1'b0, 0};
    tbl[7]  = '{4'b0000, 1'b0, 1,   100, 168, 1'b1, 1'b0, 1'b0, 0};
    tbl[8]  = '{4'b0000, 1'b0, 31,  100, 199, 1'b1, 1'b0, 1'b0, 0};
    tbl[9]  = '{4'b0000, 1'b0, 1,   100, 199, 1'b0, 1'b0, 1'b0, 0};
    tbl[10] = '{4'b1000, 1'b1, 1,   100, 199, 1'b1, 1'b0, 1'b0, 0};
    tbl[11] = '{4'b0000, 1'b1, 8,   100, 191, 1'b1, 1'b0, 1'b0, 0};
    tbl[12] = '{4'b0000, 1'b1, 1,   100, 191, 1'b1, 1'b0, 1'b0, 0};
    tbl[13] = '{4'b0000, 1'b1, 1,   100, 192, 1'b1, 1'b0, 1'b0, 0};
    tbl[14] = '{4'b0000, 1'b1, 7,   100, 199, 1'b1, 1'b0, 1'b0, 0};
    tbl[15] = '{4'b0000, 1'b1, 1,   100, 199, 1'b0, 1'b0, 1'b0, 0};

    // Reset state
    repeat (3) @(negedge sys_clk);
    check("rst_x_m", int'(cx_m), 100);
    check("rst_y_m", int'(cy_m), 34);
    check("rst_air_m", int'(air_m), 1);
    check("rst_req_m", int'(mreq_m), 0);
    check("rst_tick", int'(tk_m | tk_w | tk_nw), 0);
    check("rst_x_w", int'(cx_w), 639);

    // First tick: all three start falling; u_w wraps right, u_nw is blocked.
    mov_w = 4'b0001;
    mov_nw = 4'b0001;
    rst_n = 1'b1;
    do_tick();
    check("t1_y_m", int'(cy_m), 35);
    check("t1_air_m", int'(air_m), 1);
    check("wrap_hreq", int'(hreq_w), 1);
    check("wrap_hx", int'(hx_w), 0);
    check("wrap_x", int'(cx_w), 0);
    check("wrap_y", int'(cy_w), 35);
    check("block_hreq", int'(hreq_nw), 0);
    check("block_x", int'(cx_nw), 639);
    mov_w = '0;
    mov_nw = '0;

    // Table-driven scenario on u_m
    for (int i = 0; i < 16; i++) begin
      mov_m = tbl[i].mov;
      ceil_on = tbl[i].ceil;
      repeat (tbl[i].n) do_tick();
      check($sformatf("v%0d_x", i), int'(cx_m), tbl[i].ex);
      check($sformatf("v%0d_y", i), int'(cy_m), tbl[i].ey);
      check($sformatf("v%0d_air", i), int'(air_m), int'(tbl[i].eair));
      if (tbl[i].chk_h) begin
        check($sformatf("v%0d_hreq", i), int'(hreq_m), int'(tbl[i].ehreq));
        if (tbl[i].ehreq) check($sformatf("v%0d_hx", i), int'(hx_m), tbl[i].ehx);
      end
    end

    // u_w reaches the screen floor and then issues no probes at all.
    repeat (200) do_tick();
    check("floor_y_w", int'(cy_w), 479);
    check("floor_air_w", int'(air_w), 0);
    wcnt = 0;
    repeat (3) do_tick();
    check("floor_noprobe_w", wcnt, 0);
    check("floor_hold_w", int'(cy_w), 479);

    // Reset asserted during WAIT_V, then tick spacing after release.
    mov_m = 4'b0001;
    wait_tick();
    repeat (4) @(negedge sys_clk);
    check("pre_rst_x", int'(cx_m), 101);
    rst_n = 1'b0;
    @(negedge sys_clk);
    check("mid_rst_x", int'(cx_m), 100);
    check("mid_rst_y", int'(cy_m), 34);
    check("mid_rst_air", int'(air_m), 1);
    check("mid_rst_req", int'(mreq_m), 0);
    mov_m = '0;
    rst_n = 1'b1;
    k = 0;
    do begin
      @(negedge sys_clk);
      k++;
      if (!tk_m && k == 8) check("pre_tick_y", int'(cy_m), 34);
    end while (!tk_m && k < 20);
    check("rel_tick_gap", k, 9);
    repeat (5) @(negedge sys_clk);
    check("post_rst_y", int'(cy_m), 35);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
